// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file front end: FunSel codes, output-select
// codes and the FSM state type.
package regfile_pkg;

  // Register-file FunSel operations
  localparam logic [1:0] FUN_CLR = 2'b00;
  localparam logic [1:0] FUN_LD  = 2'b01;
  localparam logic [1:0] FUN_DEC = 2'b10;
  localparam logic [1:0] FUN_INC = 2'b11;

  // O1Sel/O2Sel codes
  localparam logic [2:0] SEL_T1 = 3'b000;
  localparam logic [2:0] SEL_T2 = 3'b001;
  localparam logic [2:0] SEL_T3 = 3'b010;
  localparam logic [2:0] SEL_T4 = 3'b011;
  localparam logic [2:0] SEL_R1 = 3'b100;
  localparam logic [2:0] SEL_R2 = 3'b101;
  localparam logic [2:0] SEL_R3 = 3'b110;
  localparam logic [2:0] SEL_R4 = 3'b111;

  localparam logic [3:0] MASK_ALL  = 4'b1111;
  localparam logic [3:0] MASK_NONE = 4'b0000;

  typedef enum logic [1:0] {
    StInit,
    StIdle,
    StIssue,
    StCapture
  } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter. The last-grant flag only moves on an
// accepted handshake, so a stalled grant is not rotated away.
module rr_arbiter2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] valid_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o
);

  // 1 = requester 1 was granted last; reset value lets requester 0 win first
  logic last_q, last_d;

  // Grant: lone valid wins, a tie goes to the requester not granted last
  always_comb begin
    gnt_o = 2'b00;
    case (valid_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

  // Last-grant next state
  always_comb begin
    last_d = last_q;
    if (accept_i) begin
      last_d = gnt_o[1];
    end
  end

  // Last-grant register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/regfile_arbiter.sv
// Two-port command front end for the register file. Each command takes three
// cycles: IDLE (handshake), ISSUE (rf_* carry the command), CAPTURE (response).
// The rf_* flops plus owner_q form the command register.
module regfile_arbiter
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [1:0] req0_fun,
  input  logic [3:0] req0_rsel,
  input  logic [3:0] req0_tsel,
  input  logic [2:0] req0_o1sel,
  input  logic [2:0] req0_o2sel,
  input  logic [7:0] req0_data,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [1:0] req1_fun,
  input  logic [3:0] req1_rsel,
  input  logic [3:0] req1_tsel,
  input  logic [2:0] req1_o1sel,
  input  logic [2:0] req1_o2sel,
  input  logic [7:0] req1_data,
  output logic       rsp0_valid,
  output logic       rsp1_valid,
  output logic [7:0] rsp_o1,
  output logic [7:0] rsp_o2,
  output logic [7:0] rf_I,
  output logic [1:0] rf_FunSel,
  output logic [3:0] rf_RSel,
  output logic [3:0] rf_TSel,
  output logic [2:0] rf_O1Sel,
  output logic [2:0] rf_O2Sel,
  input  logic [7:0] rf_O1,
  input  logic [7:0] rf_O2
);

  state_e     state_q, state_d;
  logic       owner_q, owner_d;
  logic [1:0] fun_q, fun_d;
  logic [3:0] rsel_q, rsel_d;
  logic [3:0] tsel_q, tsel_d;
  logic [7:0] data_q, data_d;
  logic [2:0] o1sel_q, o1sel_d;
  logic [2:0] o2sel_q, o2sel_d;

  logic [1:0] valid;
  logic [1:0] gnt;
  logic [1:0] ready;
  logic       accept;

  assign valid  = {req1_valid, req0_valid};
  assign ready  = gnt & {2{state_q == StIdle}};
  assign accept = |ready;

  assign req0_ready = ready[0];
  assign req1_ready = ready[1];

  rr_arbiter2 u_arb (
    .clk_i   (clk),
    .rst_i   (rst),
    .valid_i (valid),
    .accept_i(accept),
    .gnt_o   (gnt)
  );

  // Next state; fun/rsel/tsel default to a no-op so they only carry a command in ISSUE
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    fun_d   = FUN_CLR;
    rsel_d  = MASK_NONE;
    tsel_d  = MASK_NONE;
    data_d  = data_q;
    o1sel_d = o1sel_q;
    o2sel_d = o2sel_q;
    case (state_q)
      StInit: begin
        state_d = StIdle;
      end
      StIdle: begin
        if (accept) begin
          state_d = StIssue;
          owner_d = gnt[1];
          if (gnt[1]) begin
            fun_d   = req1_fun;
            rsel_d  = req1_rsel;
            tsel_d  = req1_tsel;
            data_d  = req1_data;
            o1sel_d = req1_o1sel;
            o2sel_d = req1_o2sel;
          end else begin
            fun_d   = req0_fun;
            rsel_d  = req0_rsel;
            tsel_d  = req0_tsel;
            data_d  = req0_data;
            o1sel_d = req0_o1sel;
            o2sel_d = req0_o2sel;
          end
        end
      end
      StIssue: begin
        state_d = StCapture;
      end
      StCapture: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StInit;
      end
    endcase
  end

  // State and command registers; reset drives the clear-all command seen during INIT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StInit;
      owner_q <= 1'b0;
      fun_q   <= FUN_CLR;
      rsel_q  <= MASK_ALL;
      tsel_q  <= MASK_ALL;
      data_q  <= 8'h00;
      o1sel_q <= SEL_T1;
      o2sel_q <= SEL_T1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      fun_q   <= fun_d;
      rsel_q  <= rsel_d;
      tsel_q  <= tsel_d;
      data_q  <= data_d;
      o1sel_q <= o1sel_d;
      o2sel_q <= o2sel_d;
    end
  end

  assign rf_FunSel = fun_q;
  assign rf_RSel   = rsel_q;
  assign rf_TSel   = tsel_q;
  assign rf_I      = data_q;
  assign rf_O1Sel  = o1sel_q;
  assign rf_O2Sel  = o2sel_q;

  // rf_O1/rf_O2 were sampled on the ISSUE closing edge, so they are valid in CAPTURE
  assign rsp0_valid = (state_q == StCapture) && !owner_q;
  assign rsp1_valid = (state_q == StCapture) && owner_q;
  assign rsp_o1     = rf_O1;
  assign rsp_o2     = rf_O2;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: a behavioural register file hangs off the rf_* port,
// directed vectors and random commands are checked against an array model.
module tb_regfile_arbiter;
  import regfile_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [1:0] req0_fun = '0, req1_fun = '0;
  logic [3:0] req0_rsel = '0, req1_rsel = '0, req0_tsel = '0, req1_tsel = '0;
  logic [2:0] req0_o1sel = '0, req1_o1sel = '0, req0_o2sel = '0, req1_o2sel = '0;
  logic [7:0] req0_data = '0, req1_data = '0;
  logic       rsp0_valid, rsp1_valid;
  logic [7:0] rsp_o1, rsp_o2;
  logic [7:0] rf_I;
  logic [1:0] rf_FunSel;
  logic [3:0] rf_RSel, rf_TSel;
  logic [2:0] rf_O1Sel, rf_O2Sel;
  logic [7:0] rf_O1, rf_O2;

  int total = 0;
  int bad = 0;

  logic       scramble = 1'b1;
  logic [7:0] rf_mem[8];
  logic [7:0] mdl[8];
  int         last_grant = 1;

  always #5 clk = ~clk;

  regfile_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req0_fun  (req0_fun),
    .req0_rsel (req0_rsel),
    .req0_tsel (req0_tsel),
    .req0_o1sel(req0_o1sel),
    .req0_o2sel(req0_o2sel),
    .req0_data (req0_data),
    .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .req1_fun  (req1_fun),
    .req1_rsel (req1_rsel),
    .req1_tsel (req1_tsel),
    .req1_o1sel(req1_o1sel),
    .req1_o2sel(req1_o2sel),
    .req1_data (req1_data),
    .rsp0_valid(rsp0_valid),
    .rsp1_valid(rsp1_valid),
    .rsp_o1    (rsp_o1),
    .rsp_o2    (rsp_o2),
    .rf_I      (rf_I),
    .rf_FunSel (rf_FunSel),
    .rf_RSel   (rf_RSel),
    .rf_TSel   (rf_TSel),
    .rf_O1Sel  (rf_O1Sel),
    .rf_O2Sel  (rf_O2Sel),
    .rf_O1     (rf_O1),
    .rf_O2     (rf_O2)
  );

  function automatic logic [7:0] fun_val(logic [1:0] f, logic [7:0] old, logic [7:0] d);
    case (f)
      FUN_CLR: return 8'h00;
      FUN_LD:  return d;
      FUN_DEC: return old - 8'd1;
      default: return old + 8'd1;
    endcase
  endfunction

  // Register file: index 0-3 = T1-T4, 4-7 = R1-R4; outputs registered, read-before-write
  always @(posedge clk) begin
    rf_O1 <= rf_mem[rf_O1Sel];
    rf_O2 <= rf_mem[rf_O2Sel];
    if (scramble) begin
      for (int i = 0; i < 8; i++) rf_mem[i] <= 8'($urandom);
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (rf_RSel[b]) rf_mem[7-b] <= fun_val(rf_FunSel, rf_mem[7-b], rf_I);
        if (rf_TSel[b]) rf_mem[3-b] <= fun_val(rf_FunSel, rf_mem[3-b], rf_I);
      end
    end
  end

  function automatic void mdl_apply(logic [1:0] f, logic [3:0] rs, logic [3:0] ts,
                                    logic [7:0] d);
    for (int b = 0; b < 4; b++) begin
      if (rs[b]) mdl[7-b] = fun_val(f, mdl[7-b], d);
      if (ts[b]) mdl[3-b] = fun_val(f, mdl[3-b], d);
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Ready must stay low for the two cycles following every handshake; responses never overlap
  int busy = 0;
  always begin
    @(negedge clk);
    #3;
    if (busy > 0) begin
      chk("ready_outside_idle", {31'd0, req0_ready | req1_ready}, 32'd0);
      busy--;
    end
    if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) busy = 2;
    if (rsp0_valid || rsp1_valid) chk("rsp_overlap", {31'd0, rsp0_valid & rsp1_valid}, 32'd0);
  end

  // One command from requester id; called and returns at a falling edge
  task automatic run_cmd(input int id, input logic [1:0] f, input logic [3:0] rs,
                         input logic [3:0] ts, input logic [2:0] s1, input logic [2:0] s2,
                         input logic [7:0] d, output logic [7:0] g1, output logic [7:0] g2);
    int n;
    if (id == 0) begin
      req0_fun = f; req0_rsel = rs; req0_tsel = ts; req0_o1sel = s1; req0_o2sel = s2;
      req0_data = d; req0_valid = 1'b1;
    end else begin
      req1_fun = f; req1_rsel = rs; req1_tsel = ts; req1_o1sel = s1; req1_o2sel = s2;
      req1_data = d; req1_valid = 1'b1;
    end
    #1;
    n = 0;
    while (!((id == 0) ? req0_ready : req1_ready) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("grant_timeout", {31'd0, n < 20}, 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    chk("issue_no_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    chk("issue_cmd", {rf_FunSel, rf_RSel, rf_TSel, rf_I, rf_O1Sel, rf_O2Sel},
        {f, rs, ts, d, s1, s2});
    @(negedge clk);
    chk("capture_rsp", {30'd0, rsp1_valid, rsp0_valid}, (id == 0) ? 32'd1 : 32'd2);
    chk("capture_noop_hold", {rf_FunSel, rf_RSel, rf_TSel, rf_I, rf_O1Sel, rf_O2Sel},
        {FUN_CLR, MASK_NONE, MASK_NONE, d, s1, s2});
    g1 = rsp_o1;
    g2 = rsp_o2;
    last_grant = id;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; scramble = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0; scramble = 1'b0;
    for (int i = 0; i < 8; i++) mdl[i] = 8'h00;
    last_grant = 1;
    @(negedge clk);
  endtask

  typedef struct {
    int         id;
    logic [1:0] fun;
    logic [3:0] rsel;
    logic [3:0] tsel;
    logic [2:0] o1;
    logic [2:0] o2;
    logic [7:0] data;
    logic [7:0] e1;
    logic [7:0] e2;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [7:0] g1, g2, e1, e2;
    int id, n, g, exp_id;
    logic [1:0] f;
    logic [3:0] rs, ts;
    logic [2:0] s1, s2;
    logic [7:0] d;

    vecs[0]  = '{0, FUN_LD,  4'b1000, 4'b0000, SEL_R1, SEL_T1, 8'h5A, 8'h00, 8'h00};
    vecs[1]  = '{0, FUN_LD,  4'b0000, 4'b0000, SEL_R1, SEL_T1, 8'h00, 8'h5A, 8'h00};
    vecs[2]  = '{1, FUN_LD,  4'b0001, 4'b0000, SEL_R4, SEL_R1, 8'hFF, 8'h00, 8'h5A};
    vecs[3]  = '{1, FUN_INC, 4'b0001, 4'b0000, SEL_R4, SEL_T1, 8'h00, 8'hFF, 8'h00};
    vecs[4]  = '{0, FUN_CLR, 4'b0000, 4'b0000, SEL_R4, SEL_R1, 8'h00, 8'h00, 8'h5A};
    vecs[5]  = '{0, FUN_DEC, 4'b0000, 4'b1000, SEL_T1, SEL_R4, 8'h00, 8'h00, 8'h00};
    vecs[6]  = '{1, FUN_INC, 4'b0000, 4'b0000, SEL_T1, SEL_T2, 8'h11, 8'hFF, 8'h00};
    vecs[7]  = '{0, FUN_CLR, 4'b1000, 4'b1000, SEL_R1, SEL_T1, 8'h00, 8'h5A, 8'hFF};
    vecs[8]  = '{0, FUN_LD,  4'b0000, 4'b0000, SEL_R1, SEL_T1, 8'h77, 8'h00, 8'h00};
    vecs[9]  = '{1, FUN_LD,  4'b0110, 4'b0011, SEL_R2, SEL_R3, 8'h3C, 8'h00, 8'h00};
    vecs[10] = '{1, FUN_INC, 4'b0000, 4'b0000, SEL_R2, SEL_T4, 8'h00, 8'h3C, 8'h3C};

    // Reset values, with a requester already asking
    req0_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_rf_cmd", {rf_FunSel, rf_RSel, rf_TSel, rf_I, rf_O1Sel, rf_O2Sel},
        {FUN_CLR, MASK_ALL, MASK_ALL, 8'h00, 3'b000, 3'b000});
    chk("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    chk("rst_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    req0_valid = 1'b0;
    rst = 1'b0;
    scramble = 1'b0;
    #1;
    chk("init_clear_all", {rf_FunSel, rf_RSel, rf_TSel}, {FUN_CLR, MASK_ALL, MASK_ALL});
    @(negedge clk);
    chk("idle_noop", {rf_FunSel, rf_RSel, rf_TSel}, {FUN_CLR, MASK_NONE, MASK_NONE});
    for (int i = 0; i < 8; i++) mdl[i] = 8'h00;

    run_cmd(0, FUN_CLR, 4'b0000, 4'b0000, SEL_R1, SEL_T1, 8'h00, g1, g2);
    chk("first_read_o1", {24'd0, g1}, 32'h00);
    chk("first_read_o2", {24'd0, g2}, 32'h00);

    // Directed vectors: loads, wrap on increment/decrement, clears, read-only commands
    for (int i = 0; i < 11; i++) begin
      run_cmd(vecs[i].id, vecs[i].fun, vecs[i].rsel, vecs[i].tsel, vecs[i].o1, vecs[i].o2,
              vecs[i].data, g1, g2);
      chk($sformatf("vec%0d_o1", i), {24'd0, g1}, {24'd0, vecs[i].e1});
      chk($sformatf("vec%0d_o2", i), {24'd0, g2}, {24'd0, vecs[i].e2});
      mdl_apply(vecs[i].fun, vecs[i].rsel, vecs[i].tsel, vecs[i].data);
    end

    // Random lone-requester commands against the array model
    for (int i = 0; i < 40; i++) begin
      id = $urandom_range(0, 1);
      f  = 2'($urandom);
      rs = 4'($urandom);
      ts = 4'($urandom);
      s1 = 3'($urandom);
      s2 = 3'($urandom);
      d  = 8'($urandom);
      e1 = mdl[s1];
      e2 = mdl[s2];
      mdl_apply(f, rs, ts, d);
      run_cmd(id, f, rs, ts, s1, s2, d, g1, g2);
      chk($sformatf("rnd%0d_o1", i), {24'd0, g1}, {24'd0, e1});
      chk($sformatf("rnd%0d_o2", i), {24'd0, g2}, {24'd0, e2});
    end

    // Reset during ISSUE of a load R2=33: command dropped, no response
    req0_fun = FUN_LD; req0_rsel = 4'b0100; req0_tsel = 4'b0000;
    req0_o1sel = SEL_R2; req0_o2sel = SEL_R2; req0_data = 8'h33; req0_valid = 1'b1;
    #1;
    n = 0;
    while (!req0_ready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("rstissue_grant", {31'd0, n < 20}, 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    #1;
    rst = 1'b1; scramble = 1'b1;
    #1;
    chk("async_rst_rf", {rf_FunSel, rf_RSel, rf_TSel, rf_I, rf_O1Sel, rf_O2Sel},
        {FUN_CLR, MASK_ALL, MASK_ALL, 8'h00, 3'b000, 3'b000});
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("rstissue_no_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    end
    rst = 1'b0; scramble = 1'b0;
    #1;
    chk("reinit_clear_all", {rf_FunSel, rf_RSel, rf_TSel}, {FUN_CLR, MASK_ALL, MASK_ALL});
    chk("reinit_no_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    for (int i = 0; i < 8; i++) mdl[i] = 8'h00;
    last_grant = 1;
    @(negedge clk);
    run_cmd(0, FUN_LD, 4'b0000, 4'b0000, SEL_R2, SEL_T3, 8'h00, g1, g2);
    chk("after_rst_r2", {24'd0, g1}, 32'h00);

    // Both requesters held valid for four commands: grants alternate from req0
    do_reset();
    req0_fun = FUN_INC; req0_rsel = 4'b1000; req0_tsel = 4'b0000;
    req0_o1sel = SEL_R1; req0_o2sel = SEL_T4; req0_data = 8'h00; req0_valid = 1'b1;
    req1_fun = FUN_DEC; req1_rsel = 4'b0000; req1_tsel = 4'b0001;
    req1_o1sel = SEL_T4; req1_o2sel = SEL_R1; req1_data = 8'h00; req1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      n = 0;
      while (!(req0_ready || req1_ready) && n < 20) begin
        @(negedge clk); #1; n++;
      end
      chk("arb_timeout", {31'd0, n < 20}, 32'd1);
      chk("arb_onehot", {31'd0, req0_ready & req1_ready}, 32'd0);
      if (k > 0) chk("arb_throughput", n, 32'd1);
      exp_id = (last_grant == 1) ? 0 : 1;
      g = req1_ready ? 1 : 0;
      chk($sformatf("arb_grant%0d", k), g, exp_id);
      if (exp_id == 0) begin
        e1 = mdl[SEL_R1]; e2 = mdl[SEL_T4]; mdl_apply(FUN_INC, 4'b1000, 4'b0000, 8'h00);
      end else begin
        e1 = mdl[SEL_T4]; e2 = mdl[SEL_R1]; mdl_apply(FUN_DEC, 4'b0000, 4'b0001, 8'h00);
      end
      last_grant = exp_id;
      @(negedge clk);
      @(negedge clk);
      chk($sformatf("arb_rsp%0d", k), {30'd0, rsp1_valid, rsp0_valid},
          (exp_id == 0) ? 32'd1 : 32'd2);
      chk($sformatf("arb_data%0d", k), {16'd0, rsp_o1, rsp_o2}, {16'd0, e1, e2});
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

endmodule
